shift_iterativo: RTL and testbench

Multi-cycle, parametrised shift/rotate unit for the ALU path, where area matters more than single-cycle latency. It accepts an operand, a shift amount and an operation through a start/ready handshake. It then shifts up to PASO bit positions per clock and presents the result with a one-cycle valid pulse. It adds rotates, amount masking and a sequential datapath that a purely combinational shifter does not have.

---
 rtl/shift_pkg.sv | 39 +++
 rtl/shift_paso.sv | 58 +++++
 rtl/shift_iterativo.sv | 162 ++++++++++++++++
 tb/tb_shift_iterativo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the iterative shift/rotate unit:
//   - operation codes understood by shift_paso and shift_iterativo
//   - FSM state encoding of the top module
//   - helper functions for the amount-counter width and opcode validity
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    DESPLAZA = 2'b01,
    FIN      = 2'b10
  } estado_t;

  // Width of the amount counter: log2 of the operand width, never below 1.
  function automatic int ancho_cnt(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Codes 101..111 are reserved and produce a zero result.
  function automatic logic op_valida(input logic [2:0] op);
    return (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/shift_paso.sv
// -----------------------------------------------------------------------------
// shift_paso
// Combinational single-step shifter/rotator. Moves the working value by k
// positions (0..PASO) according to the opcode.
// Ports:
//   valor      working value to shift
//   k          positions to move this step
//   op         operation code (see shift_pkg)
//   signo      fill bit for arithmetic right shifts (captured operand MSB)
//   resultado  shifted/rotated value; zero for reserved opcodes
// -----------------------------------------------------------------------------
module shift_paso
  import shift_pkg::*;
#(
  parameter int N  = 32,
  parameter int KW = 1
) (
  input  logic [N-1:0]  valor,
  input  logic [KW-1:0] k,
  input  logic [2:0]    op,
  input  logic          signo,
  output logic [N-1:0]  resultado
);

  localparam int CW = ancho_cnt(N);
  localparam logic [CW:0] N_EXT = (CW+1)'(N);

  // Complementary amount for rotates; equals N when k is zero, so the
  // wrap-around term shifts out completely.
  logic [CW:0]  comp_s;
  logic [N-1:0] relleno_s;

  // Rotate complement and the sign-fill mask for arithmetic right shifts.
  always_comb begin
    comp_s    = N_EXT - (CW+1)'(k);
    relleno_s = ~({N{1'b1}} >> k);
  end

  // One step of the selected operation.
  always_comb begin
    resultado = {N{1'b0}};
    case (op)
      OP_SLL:  resultado = valor << k;
      OP_SRL:  resultado = valor >> k;
      OP_SRA: begin
        if (signo) begin
          resultado = (valor >> k) | relleno_s;
        end else begin
          resultado = valor >> k;
        end
      end
      OP_ROL:  resultado = (valor << k) | (valor >> comp_s);
      OP_ROR:  resultado = (valor >> k) | (valor << comp_s);
      default: resultado = {N{1'b0}};
    endcase
  end

endmodule

// File: rtl/shift_iterativo.sv
// -----------------------------------------------------------------------------
// shift_iterativo
// Multi-cycle shift/rotate unit. Accepts an operand, amount and opcode through
// a start/ready handshake, shifts up to PASO positions per clock and reports
// the result with a one-cycle valid pulse.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active high
//   inicio_i     start request, sampled while listo_o=1
//   a_i          operand
//   b_i          shift amount, only the low log2(N) bits are used
//   operacion_i  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others invalid
//   listo_o      ready to accept a start
//   ocupado_o    shift in progress
//   valido_o     one-cycle pulse when salida_o carries a new result
//   salida_o     result, held until the next completed operation
// -----------------------------------------------------------------------------
module shift_iterativo
  import shift_pkg::*;
#(
  parameter int N    = 32,
  parameter int PASO = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inicio_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   operacion_i,
  output logic         listo_o,
  output logic         ocupado_o,
  output logic         valido_o,
  output logic [N-1:0] salida_o
);

  localparam int CW = ancho_cnt(N);
  localparam int KW = $clog2(PASO) + 1;
  localparam logic [CW:0]   PASO_EXT = (CW+1)'(PASO);
  // Only reachable when the remaining count is at least PASO, which with
  // PASO=N can never happen, so truncation there is harmless.
  localparam logic [CW-1:0] PASO_CNT = CW'(PASO);

  estado_t       estado_r;
  logic [N-1:0]  trabajo_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    op_r;
  logic          signo_r;
  logic          listo_r;
  logic          ocupado_r;
  logic          valido_r;
  logic [N-1:0]  salida_r;

  logic [CW-1:0] cnt_b_s;
  logic [CW-1:0] k_cnt_s;
  logic [CW-1:0] cnt_sig_s;
  logic [KW-1:0] k_s;
  logic [N-1:0]  paso_s;
  logic          unused_b_s;

  // Amount masking: upper bits of b_i never influence the result.
  assign cnt_b_s    = b_i[CW-1:0];
  assign unused_b_s = ^b_i[N-1:CW];

  // Step size k = min(PASO, cnt) and the count left after this step.
  always_comb begin
    if ({1'b0, cnt_r} >= PASO_EXT) begin
      k_cnt_s = PASO_CNT;
    end else begin
      k_cnt_s = cnt_r;
    end
    cnt_sig_s = cnt_r - k_cnt_s;
    k_s       = KW'(k_cnt_s);
  end

  shift_paso #(
    .N  (N),
    .KW (KW)
  ) u_paso (
    .valor     (trabajo_r),
    .k         (k_s),
    .op        (op_r),
    .signo     (signo_r),
    .resultado (paso_s)
  );

  // Control FSM with counter, working register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estado_r  <= REPOSO;
      trabajo_r <= {N{1'b0}};
      cnt_r     <= {CW{1'b0}};
      op_r      <= OP_SLL;
      signo_r   <= 1'b0;
      listo_r   <= 1'b1;
      ocupado_r <= 1'b0;
      valido_r  <= 1'b0;
      salida_r  <= {N{1'b0}};
    end else begin
      case (estado_r)
        REPOSO, FIN: begin
          if (inicio_i) begin
            trabajo_r <= a_i;
            cnt_r     <= cnt_b_s;
            op_r      <= operacion_i;
            signo_r   <= a_i[N-1];
            if ((cnt_b_s != {CW{1'b0}}) && op_valida(operacion_i)) begin
              estado_r  <= DESPLAZA;
              listo_r   <= 1'b0;
              ocupado_r <= 1'b1;
              valido_r  <= 1'b0;
            end else begin
              // Nothing to iterate: result is available after one edge.
              estado_r  <= FIN;
              listo_r   <= 1'b1;
              ocupado_r <= 1'b0;
              valido_r  <= 1'b1;
              if (op_valida(operacion_i)) begin
                salida_r <= a_i;
              end else begin
                salida_r <= {N{1'b0}};
              end
            end
          end else begin
            estado_r  <= REPOSO;
            listo_r   <= 1'b1;
            ocupado_r <= 1'b0;
            valido_r  <= 1'b0;
          end
        end
        DESPLAZA: begin
          // Starts arriving here are dropped, not queued.
          trabajo_r <= paso_s;
          cnt_r     <= cnt_sig_s;
          if (cnt_sig_s == {CW{1'b0}}) begin
            estado_r  <= FIN;
            listo_r   <= 1'b1;
            ocupado_r <= 1'b0;
            valido_r  <= 1'b1;
            salida_r  <= paso_s;
          end else begin
            estado_r  <= DESPLAZA;
            listo_r   <= 1'b0;
            ocupado_r <= 1'b1;
            valido_r  <= 1'b0;
          end
        end
        default: begin
          estado_r  <= REPOSO;
          listo_r   <= 1'b1;
          ocupado_r <= 1'b0;
          valido_r  <= 1'b0;
        end
      endcase
    end
  end

  assign listo_o   = listo_r;
  assign ocupado_o = ocupado_r;
  assign valido_o  = valido_r;
  assign salida_o  = salida_r;

endmodule

// File: tb/tb_shift_iterativo.sv
module tb_shift_iterativo;

  localparam logic [2:0] SLL = 3'b000;
  localparam logic [2:0] SRL = 3'b001;
  localparam logic [2:0] SRA = 3'b010;
  localparam logic [2:0] ROL = 3'b011;
  localparam logic [2:0] ROR = 3'b100;

  logic        clk;
  logic        rst;
  logic        inicio;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;

  logic        listo1, ocupado1, valido1;
  logic [31:0] salida1;
  logic        listo4, ocupado4, valido4;
  logic [31:0] salida4;

  int n_cmp;
  int n_err;

  shift_iterativo #(.N(32), .PASO(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .inicio_i(inicio), .a_i(a), .b_i(b),
    .operacion_i(op), .listo_o(listo1), .ocupado_o(ocupado1),
    .valido_o(valido1), .salida_o(salida1)
  );

  shift_iterativo #(.N(32), .PASO(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .inicio_i(inicio), .a_i(a), .b_i(b),
    .operacion_i(op), .listo_o(listo4), .ocupado_o(ocupado4),
    .valido_o(valido4), .salida_o(salida4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) until both units are ready; called at a negedge.
  task automatic wait_idle();
    int n;
    n = 0;
    while (!(listo1 && listo4) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Start one operation and measure the latency on unit sel (0: PASO=1,
  // 1: PASO=4). lat counts edges with the accepting edge as 1; -1 on timeout.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                        input logic [2:0] vop, input int sel,
                        output logic [31:0] res, output int lat);
    logic v;
    wait_idle();
    a = va; b = vb; op = vop; inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    lat = 1;
    v = (sel == 0) ? valido1 : valido4;
    while (!v && lat < 100) begin
      @(negedge clk);
      lat++;
      v = (sel == 0) ? valido1 : valido4;
    end
    if (!v) lat = -1;
    res = (sel == 0) ? salida1 : salida4;
  endtask

  task automatic test_reset();
    // Reset wins over a simultaneous start with b=0.
    @(negedge clk);
    rst = 1'b1; inicio = 1'b1; a = 32'h0000_0055; b = 32'd0; op = SLL;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (valido1 !== 1'b0) begin n_err++; $display("FAIL reset_valido1: got %b want 0", valido1); end
    n_cmp++; if (salida1 !== 32'h0) begin n_err++; $display("FAIL reset_salida1: got %h want 00000000", salida1); end
    n_cmp++; if (listo1 !== 1'b1) begin n_err++; $display("FAIL reset_listo1: got %b want 1", listo1); end
    n_cmp++; if (ocupado1 !== 1'b0) begin n_err++; $display("FAIL reset_ocupado1: got %b want 0", ocupado1); end
    n_cmp++; if ({valido4, listo4, ocupado4} !== 3'b010) begin n_err++; $display("FAIL reset_flags4: got %b want 010", {valido4, listo4, ocupado4}); end
    n_cmp++; if (salida4 !== 32'h0) begin n_err++; $display("FAIL reset_salida4: got %h want 00000000", salida4); end
    rst = 1'b0; inicio = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sra();
    logic [31:0] r; int l;
    run_op(32'h8000_0001, 32'd4, SRA, 0, r, l);
    n_cmp++; if (r !== 32'hF800_0000) begin n_err++; $display("FAIL sra_result: got %h want f8000000", r); end
    n_cmp++; if (l !== 5) begin n_err++; $display("FAIL sra_latency: got %0d want 5", l); end
    n_cmp++; if (salida4 !== 32'hF800_0000) begin n_err++; $display("FAIL sra_result_p4: got %h want f8000000", salida4); end
    @(negedge clk);
    n_cmp++; if (valido1 !== 1'b0) begin n_err++; $display("FAIL sra_pulse_width: got %b want 0", valido1); end
    run_op(32'h8000_0001, 32'd4, SRA, 1, r, l);
    n_cmp++; if (l !== 2) begin n_err++; $display("FAIL sra_latency_p4: got %0d want 2", l); end
  endtask

  task automatic test_rotate();
    logic [31:0] r; int l;
    run_op(32'h8000_0001, 32'd4, ROR, 0, r, l);
    n_cmp++; if (r !== 32'h1800_0000) begin n_err++; $display("FAIL ror_result: got %h want 18000000", r); end
    n_cmp++; if (salida4 !== 32'h1800_0000) begin n_err++; $display("FAIL ror_result_p4: got %h want 18000000", salida4); end
    run_op(32'h8000_0001, 32'd1, ROL, 0, r, l);
    n_cmp++; if (r !== 32'h0000_0003) begin n_err++; $display("FAIL rol_result: got %h want 00000003", r); end
    n_cmp++; if (l !== 2) begin n_err++; $display("FAIL rol_latency: got %0d want 2", l); end
  endtask

  task automatic test_paso4();
    logic [31:0] r; int l;
    run_op(32'h0000_0001, 32'd31, SLL, 1, r, l);
    n_cmp++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL sll31_result_p4: got %h want 80000000", r); end
    n_cmp++; if (l !== 9) begin n_err++; $display("FAIL sll31_latency_p4: got %0d want 9", l); end
    run_op(32'h0000_00A0, 32'd37, SRL, 1, r, l);
    n_cmp++; if (r !== 32'h0000_0005) begin n_err++; $display("FAIL srl_mask_result_p4: got %h want 00000005", r); end
    n_cmp++; if (l !== 3) begin n_err++; $display("FAIL srl_mask_latency_p4: got %0d want 3", l); end
    wait_idle();
    n_cmp++; if (salida1 !== 32'h0000_0005) begin n_err++; $display("FAIL srl_mask_result_p1: got %h want 00000005", salida1); end
  endtask

  task automatic test_zero_invalid();
    logic [31:0] r; int l;
    run_op(32'h1234_5678, 32'd0, SLL, 0, r, l);
    n_cmp++; if (r !== 32'h1234_5678) begin n_err++; $display("FAIL zero_amt_result: got %h want 12345678", r); end
    n_cmp++; if (l !== 1) begin n_err++; $display("FAIL zero_amt_latency: got %0d want 1", l); end
    run_op(32'h1234_5678, 32'd5, 3'b111, 0, r, l);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL invalid_op_result: got %h want 00000000", r); end
    n_cmp++; if (l !== 1) begin n_err++; $display("FAIL invalid_op_latency: got %0d want 1", l); end
    n_cmp++; if ({valido4, salida4} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL invalid_op_p4: got %b/%h want 1/00000000", valido4, salida4); end
  endtask

  task automatic test_back_to_back();
    int l;
    wait_idle();
    a = 32'hF000_0000; b = 32'd20; op = SRL; inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Start with other data while both units are still shifting.
    a = 32'hFFFF_FFFF; b = 32'd1; op = SLL; inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    n_cmp++; if ({ocupado1, ocupado4} !== 2'b11) begin n_err++; $display("FAIL ignore_busy: got %b want 11", {ocupado1, ocupado4}); end
    l = 3;
    while (!valido1 && l < 100) begin
      @(negedge clk);
      l++;
    end
    n_cmp++; if (l !== 21) begin n_err++; $display("FAIL ignore_latency: got %0d want 21", l); end
    n_cmp++; if (salida1 !== 32'h0000_0F00) begin n_err++; $display("FAIL ignore_result: got %h want 00000f00", salida1); end
    n_cmp++; if (salida4 !== 32'h0000_0F00) begin n_err++; $display("FAIL ignore_result_p4: got %h want 00000f00", salida4); end
    n_cmp++; if (listo1 !== 1'b1) begin n_err++; $display("FAIL fin_listo: got %b want 1", listo1); end
    // New start while unit 1 sits in FIN.
    a = 32'h0000_000F; b = 32'd2; op = SLL; inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    l = 1;
    while (!valido1 && l < 100) begin
      @(negedge clk);
      l++;
    end
    n_cmp++; if (l !== 3) begin n_err++; $display("FAIL b2b_latency: got %0d want 3", l); end
    n_cmp++; if (salida1 !== 32'h0000_003C) begin n_err++; $display("FAIL b2b_result: got %h want 0000003c", salida1); end
  endtask

  task automatic test_reset_abort();
    int pulses;
    logic [31:0] r; int l;
    wait_idle();
    a = 32'h1234_5678; b = 32'd20; op = SRL; inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (salida1 !== 32'h0) begin n_err++; $display("FAIL abort_salida: got %h want 00000000", salida1); end
    n_cmp++; if ({listo1, ocupado1, valido1} !== 3'b100) begin n_err++; $display("FAIL abort_flags: got %b want 100", {listo1, ocupado1, valido1}); end
    n_cmp++; if (salida4 !== 32'h0) begin n_err++; $display("FAIL abort_salida_p4: got %h want 00000000", salida4); end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valido1 || valido4) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL abort_no_pulse: got %0d pulses want 0", pulses); end
    run_op(32'h0000_0001, 32'd1, SLL, 0, r, l);
    n_cmp++; if ({l, r} !== {32'd2, 32'h0000_0002}) begin n_err++; $display("FAIL after_abort: got lat %0d res %h want 2/00000002", l, r); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; inicio = 1'b0; a = 32'h0; b = 32'h0; op = SLL;
    repeat (3) @(posedge clk);
    test_reset();
    test_sra();
    test_rotate();
    test_paso4();
    test_zero_invalid();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
